commit_bus_arbiter: RTL



---
 rtl/commit_bus_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/commit_bus_arbiter.sv
// -----------------------------------------------------------------------------
// commit_bus_arbiter
//
// Chooses at most one finished execution station per clock and drives the
// single shared commit bus. The winning station receives a one-cycle grant
// pulse. Its packet is registered onto oCommitBus, together with
// oCommitValid, for the register file and for operand forwarding.
//
// A station whose grant is currently visible is masked out of the next
// arbitration. That station is still holding its request during that cycle,
// and without the mask it would win twice.
//
// Build option:
//   COMMIT_ARB_FIXED_PRIORITY_EN  defined   -> lowest-index eligible station
//                                              wins; no pointer register.
//                                 undefined -> round-robin from pointer p,
//                                              with p <- winner+1 after each
//                                              grant.
//
// Ports:
//   Clock         in   system clock, rising edge
//   Reset         in   asynchronous active-low reset
//   iRequest      in   [NUM_STATIONS]  bit i = station i has a finished result
//   iCommitData   in   [NUM_STATIONS*PACKET_W]  station i packet at
//                      [i*PACKET_W +: PACKET_W]
//   iStall        in   register file cannot take a commit this cycle
//   oGrant        out  [NUM_STATIONS]  one-hot grant pulse to the winner
//   oCommitValid  out  oCommitBus carries a valid commit this cycle
//   oCommitBus    out  [PACKET_W]  registered winning packet (holds when idle)
// -----------------------------------------------------------------------------
module commit_bus_arbiter #(
  parameter int NUM_STATIONS = 4,
  parameter int PACKET_W     = 111,
  parameter int PTR_W        = 2
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic [NUM_STATIONS-1:0]          iRequest,
  input  logic [NUM_STATIONS*PACKET_W-1:0] iCommitData,
  input  logic                             iStall,
  output logic [NUM_STATIONS-1:0]          oGrant,
  output logic                             oCommitValid,
  output logic [PACKET_W-1:0]              oCommitBus
);

  localparam int IDX_W = (NUM_STATIONS > 1) ? $clog2(NUM_STATIONS) : 1;

  logic [NUM_STATIONS-1:0] grant_q, grant_d;
  logic                    valid_q, valid_d;
  logic [PACKET_W-1:0]     bus_q, bus_d;

  logic [NUM_STATIONS-1:0] eligible;
  logic                    found;
  logic [IDX_W-1:0]        win_idx;
  logic [PACKET_W-1:0]     pkt [NUM_STATIONS];

  // Split the flat packet vector into one packet per station.
  generate
    for (genvar gi = 0; gi < NUM_STATIONS; gi++) begin : g_pkt
      assign pkt[gi] = iCommitData[gi*PACKET_W +: PACKET_W];
    end
  endgenerate

  // The station granted last cycle still asserts its request and must not win
  // again straight away.
  assign eligible = iRequest & ~grant_q;

`ifdef COMMIT_ARB_FIXED_PRIORITY_EN

  // Walk from the top index down, so that the lowest eligible index is the
  // last assignment and therefore wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int k = NUM_STATIONS - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        found   = 1'b1;
        win_idx = IDX_W'(k);
      end
    end
  end

`else

  logic [PTR_W-1:0] ptr_q, ptr_d;
  // One extra bit holds ptr + offset before it wraps back into range.
  logic [IDX_W:0]   cand;

  // Search p, p+1, ... with wrap-around. The first eligible station wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_STATIONS; k++) begin
      cand = (IDX_W+1)'(ptr_q) + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_STATIONS)) begin
        cand = cand - (IDX_W+1)'(NUM_STATIONS);
      end
      if (!found && eligible[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  // The pointer moves only when a grant is actually issued.
  always_comb begin
    ptr_d = ptr_q;
    if (!iStall && found) begin
      ptr_d = (win_idx == IDX_W'(NUM_STATIONS - 1)) ? '0
                                                    : PTR_W'(win_idx) + PTR_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`endif

  // Register the winner. Idle or stalled cycles clear grant and valid and
  // leave the bus holding its last packet.
  always_comb begin
    grant_d = '0;
    valid_d = 1'b0;
    bus_d   = bus_q;
    if (!iStall && found) begin
      grant_d[win_idx] = 1'b1;
      valid_d          = 1'b1;
      bus_d            = pkt[win_idx];
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      grant_q <= '0;
      valid_q <= 1'b0;
      bus_q   <= '0;
    end else begin
      grant_q <= grant_d;
      valid_q <= valid_d;
      bus_q   <= bus_d;
    end
  end

  assign oGrant       = grant_q;
  assign oCommitValid = valid_q;
  assign oCommitBus   = bus_q;

endmodule
